// File: rtl/tl_sram_mp.sv
// tl_sram_mp: multi-port TileLink-UL SRAM slave.
// NUM_PORTS independent A/D channel pairs share one single-ported memory
// through a round-robin arbiter. Each port owns a one-entry D-channel
// response slot (EMPTY/FULL), so each port has at most one request in flight.
// Optional feature macro: TL_SRAM_RANGE_CHECK_EN (address/size range check).
//
// Handshake: a beat moves on a channel in a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and a response is
// held unchanged from the cycle d_valid rises until the cycle d_ready is seen.
module tl_sram_mp #(
   parameter int                NUM_PORTS = 2,
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 4096,
   parameter int                SRC_W     = 5,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            a_valid,
   output logic [NUM_PORTS-1:0]            a_ready,
   input  logic [3*NUM_PORTS-1:0]          a_opcode,
   input  logic [4*NUM_PORTS-1:0]          a_size,
   input  logic [(DATA_W/8)*NUM_PORTS-1:0] a_mask,
   input  logic [ADDR_W*NUM_PORTS-1:0]     a_address,
   input  logic [DATA_W*NUM_PORTS-1:0]     a_data,
   input  logic [SRC_W*NUM_PORTS-1:0]      a_source,
   output logic [NUM_PORTS-1:0]            d_valid,
   input  logic [NUM_PORTS-1:0]            d_ready,
   output logic [3*NUM_PORTS-1:0]          d_opcode,
   output logic [2*NUM_PORTS-1:0]          d_param,
   output logic [4*NUM_PORTS-1:0]          d_size,
   output logic [SRC_W*NUM_PORTS-1:0]      d_source,
   output logic [NUM_PORTS-1:0]            d_sink,
   output logic [DATA_W*NUM_PORTS-1:0]     d_data,
   output logic [NUM_PORTS-1:0]            d_denied,
   output logic [NUM_PORTS-1:0]            d_corrupt,
   output logic [2:0]                      dbg_rr_ptr,
   output logic [NUM_PORTS-1:0]            dbg_slot_full
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
`ifdef TL_SRAM_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

   slot_t               slot_q [NUM_PORTS];
   slot_t               slot_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] grant;
   logic [2:0]           rr_ptr;
   logic [2:0]           win_idx;
   logic                 win_any;
   int                   cand;

   logic [2:0]           win_op;
   logic [3:0]           win_size;
   logic [BYTES-1:0]     win_mask;
   logic [ADDR_W-1:0]    win_addr;
   logic [DATA_W-1:0]    win_data;
   logic [SRC_W-1:0]     win_src;

   logic [ADDR_W-1:0]    win_off;
   logic [ADDR_W-1:0]    win_word;
   logic [IDX_W-1:0]     mem_idx;
   logic                 range_err;
   logic                 is_put;
   logic                 is_get;
   logic                 denied;
   logic                 wr_en;
   logic [BYTES-1:0]     wr_be;
   logic [2:0]           rsp_op;
   logic [DATA_W-1:0]    rsp_data;

   logic [DATA_W-1:0]    mem [DEPTH];

   // Slot state mirrors onto d_valid; eligibility allows refill while draining.
   always_comb begin
      d_valid       = '0;
      dbg_slot_full = '0;
      elig          = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         d_valid[p]       = (slot_q[p] == SLOT_FULL);
         dbg_slot_full[p] = (slot_q[p] == SLOT_FULL);
         elig[p]          = a_valid[p] && ((slot_q[p] == SLOT_EMPTY) || d_ready[p]);
      end
   end

   // Round-robin search from rr_ptr; the first eligible port wins.
   always_comb begin
      win_any = 1'b0;
      win_idx = '0;
      cand    = 0;
      grant   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!win_any && (p == cand) && elig[p]) begin
               win_any = 1'b1;
               win_idx = 3'(p);
            end
         end
      end
      // Reset forces a_ready low immediately, so no beat is taken while held.
      for (int p = 0; p < NUM_PORTS; p++)
         grant[p] = win_any && !rst && (int'(win_idx) == p);
   end

   assign a_ready = grant;

   // Select the winning port's A-channel fields.
   always_comb begin
      win_op   = '0;
      win_size = '0;
      win_mask = '0;
      win_addr = '0;
      win_data = '0;
      win_src  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (int'(win_idx) == p) begin
            win_op   = a_opcode[p*3 +: 3];
            win_size = a_size[p*4 +: 4];
            win_mask = a_mask[p*BYTES +: BYTES];
            win_addr = a_address[p*ADDR_W +: ADDR_W];
            win_data = a_data[p*DATA_W +: DATA_W];
            win_src  = a_source[p*SRC_W +: SRC_W];
         end
      end
   end

   // Address decode; the range error only matters when the check is built in.
   assign win_off   = win_addr - BASE_ADDR;
   assign win_word  = win_off >> OFF_W;
   assign mem_idx   = win_word[IDX_W-1:0];
   assign range_err = (win_addr < BASE_ADDR) || ((win_word >> IDX_W) != '0) ||
                      (win_size > 4'(OFF_W));

   assign is_put   = (win_op == 3'd0) || (win_op == 3'd1);
   assign is_get   = (win_op == 3'd4);
   assign denied   = !(is_put || is_get) || (RANGE_EN && range_err);
   assign wr_en    = (|grant) && is_put && !denied;
   assign wr_be    = (win_op == 3'd0) ? {BYTES{1'b1}} : win_mask;
   assign rsp_op   = is_get ? 3'd1 : 3'd0;
   assign rsp_data = (is_get && !denied) ? mem[mem_idx] : '0;

   // Byte-enabled write into the shared memory; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++)
            if (wr_be[b]) mem[mem_idx][b*8 +: 8] <= win_data[b*8 +: 8];
      end
   end

   // Pointer moves past the winner after every grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (win_any) begin
         if (win_idx == 3'(NUM_PORTS - 1)) rr_ptr <= '0;
         else                              rr_ptr <= win_idx + 3'd1;
      end
   end

   assign dbg_rr_ptr = rr_ptr;

   // Slot state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) slot_q[p] <= SLOT_EMPTY;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) slot_q[p] <= slot_d[p];
      end
   end

   // Slot next state: fill on grant, empty on consume unless refilled.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         slot_d[p] = slot_q[p];
         case (slot_q[p])
            SLOT_EMPTY: if (grant[p]) slot_d[p] = SLOT_FULL;
            SLOT_FULL: begin
               if (grant[p])        slot_d[p] = SLOT_FULL;
               else if (d_ready[p]) slot_d[p] = SLOT_EMPTY;
            end
            default:                slot_d[p] = SLOT_EMPTY;
         endcase
      end
   end

   // Response fields load on grant and hold while the slot is full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_opcode <= '0;
         d_size   <= '0;
         d_source <= '0;
         d_data   <= '0;
         d_denied <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
               d_opcode[p*3 +: 3]         <= rsp_op;
               d_size[p*4 +: 4]           <= win_size;
               d_source[p*SRC_W +: SRC_W] <= win_src;
               d_data[p*DATA_W +: DATA_W] <= rsp_data;
               d_denied[p]                <= denied;
            end
         end
      end
   end

   assign d_param   = '0;
   assign d_sink    = '0;
   assign d_corrupt = '0;

endmodule

// File: tb/tb_tl_sram_mp.sv
// tb_tl_sram_mp: directed and randomized bench for tl_sram_mp (2 ports).
// A cycle-level reference model (slot occupancy, round-robin pointer, word
// array keyed by index) predicts every grant and response.
module tb_tl_sram_mp;

   localparam int NP    = 2;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4096;
   localparam int SW    = 5;
   localparam int MW    = DW / 8;
   localparam logic [AW-1:0] BASE = 32'h0;

   logic               clk;
   logic               rst;
   logic [NP-1:0]      a_valid;
   logic [NP-1:0]      a_ready;
   logic [3*NP-1:0]    a_opcode;
   logic [4*NP-1:0]    a_size;
   logic [MW*NP-1:0]   a_mask;
   logic [AW*NP-1:0]   a_address;
   logic [DW*NP-1:0]   a_data;
   logic [SW*NP-1:0]   a_source;
   logic [NP-1:0]      d_valid;
   logic [NP-1:0]      d_ready;
   logic [3*NP-1:0]    d_opcode;
   logic [2*NP-1:0]    d_param;
   logic [4*NP-1:0]    d_size;
   logic [SW*NP-1:0]   d_source;
   logic [NP-1:0]      d_sink;
   logic [DW*NP-1:0]   d_data;
   logic [NP-1:0]      d_denied;
   logic [NP-1:0]      d_corrupt;
   logic [2:0]         dbg_rr_ptr;
   logic [NP-1:0]      dbg_slot_full;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit             m_full [NP];
   logic [2:0]     m_op   [NP];
   logic [3:0]     m_size [NP];
   logic [SW-1:0]  m_src  [NP];
   logic [DW-1:0]  m_data [NP];
   logic           m_den  [NP];
   int             m_rr;
   int             last_grant;
   logic [NP-1:0]  seen_ready;
   logic [DW-1:0]  model_mem [int];
   logic [DW-1:0]  exp_q[$];

   tl_sram_mp #(
      .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
      .SRC_W(SW), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
      .a_size(a_size), .a_mask(a_mask), .a_address(a_address),
      .a_data(a_data), .a_source(a_source),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
      .d_param(d_param), .d_size(d_size), .d_source(d_source),
      .d_sink(d_sink), .d_data(d_data), .d_denied(d_denied),
      .d_corrupt(d_corrupt), .dbg_rr_ptr(dbg_rr_ptr),
      .dbg_slot_full(dbg_slot_full)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model reaction to an accepted A beat on port p.
   task automatic model_accept(input int p);
      logic [2:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
      logic [3:0]    size;
      logic [AW-1:0] word;
      logic [DW-1:0] nw;
      bit            den;
      int            idx;
      op   = a_opcode[p*3 +: 3];
      addr = a_address[p*AW +: AW];
      data = a_data[p*DW +: DW];
      mask = a_mask[p*MW +: MW];
      size = a_size[p*4 +: 4];
      word = (addr - BASE) >> 2;
      den  = 1'b0;
`ifdef TL_SRAM_RANGE_CHECK_EN
      if (addr < BASE || word >= DEPTH || size > 4'd2) den = 1'b1;
`endif
      idx = int'(word % DEPTH);
      m_full[p] = 1'b1;
      m_size[p] = size;
      m_src[p]  = a_source[p*SW +: SW];
      m_data[p] = '0;
      m_den[p]  = den;
      case (op)
         3'd0, 3'd1: begin
            m_op[p] = 3'd0;
            if (!den) begin
               nw = model_mem.exists(idx) ? model_mem[idx] : 'x;
               for (int b = 0; b < MW; b++)
                  if (op == 3'd0 || mask[b]) nw[b*8 +: 8] = data[b*8 +: 8];
               model_mem[idx] = nw;
            end
         end
         3'd4: begin
            m_op[p] = 3'd1;
            if (!den) m_data[p] = model_mem.exists(idx) ? model_mem[idx] : 'x;
         end
         default: begin
            m_op[p]  = 3'd0;
            m_den[p] = 1'b1;
         end
      endcase
      m_rr = (p + 1) % NP;
   endtask

   // One clock: inputs already driven at the falling edge; compare, then advance.
   task automatic cycle_step();
      int            win;
      logic [NP-1:0] exp_rdy;
      #1;
      win = -1;
      for (int i = 0; i < NP; i++) begin
         int c;
         c = (m_rr + i) % NP;
         if (win < 0 && a_valid[c] && (!m_full[c] || d_ready[c])) win = c;
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      seen_ready = a_ready;
      check("a_ready", 64'(a_ready), 64'(exp_rdy));
      check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_rr));
      for (int p = 0; p < NP; p++) begin
         check($sformatf("d_valid%0d", p), 64'(d_valid[p]), 64'(m_full[p]));
         if (m_full[p]) begin
            check($sformatf("d_opcode%0d", p), 64'(d_opcode[p*3 +: 3]), 64'(m_op[p]));
            check($sformatf("d_size%0d", p), 64'(d_size[p*4 +: 4]), 64'(m_size[p]));
            check($sformatf("d_source%0d", p), 64'(d_source[p*SW +: SW]), 64'(m_src[p]));
            check($sformatf("d_data%0d", p), 64'(d_data[p*DW +: DW]), 64'(m_data[p]));
            check($sformatf("d_denied%0d", p), 64'(d_denied[p]), 64'(m_den[p]));
         end
      end
      for (int p = 0; p < NP; p++)
         if (m_full[p] && d_ready[p]) m_full[p] = 1'b0;
      last_grant = win;
      if (win >= 0) model_accept(win);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one request on port p until granted; returns in the response cycle.
   task automatic txn(input int p, input logic [2:0] op, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [MW-1:0] mask,
                      input logic [SW-1:0] src);
      int guard;
      guard = 0;
      a_opcode[p*3 +: 3]   = op;
      a_address[p*AW +: AW] = addr;
      a_data[p*DW +: DW]   = data;
      a_mask[p*MW +: MW]   = mask;
      a_source[p*SW +: SW] = src;
      a_size[p*4 +: 4]     = 4'd2;
      a_valid[p]           = 1'b1;
      do begin
         cycle_step();
         guard++;
      end while (last_grant != p && guard < 20);
      check("txn_grant", 64'(last_grant == p), 64'd1);
      a_valid[p] = 1'b0;
   endtask

   initial begin
      int c0, c1;
      rst       = 1'b1;
      a_valid   = '0;
      a_opcode  = '0;
      a_size    = '0;
      a_mask    = '0;
      a_address = '0;
      a_data    = '0;
      a_source  = '0;
      d_ready   = '0;
      m_rr      = 0;
      last_grant = -1;
      for (int p = 0; p < NP; p++) m_full[p] = 1'b0;

      // Reset state, with requests pending to show a_ready is held low
      repeat (2) @(negedge clk);
      a_valid = '1;
      #1;
      check("rst_a_ready", 64'(a_ready), 64'd0);
      check("rst_d_valid", 64'(d_valid), 64'd0);
      check("rst_d_opcode", 64'(d_opcode), 64'd0);
      check("rst_d_data", 64'(d_data), 64'd0);
      check("rst_d_denied", 64'(d_denied), 64'd0);
      check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      a_valid = '0;
      rst     = 1'b0;
      @(negedge clk);
      d_ready = '1;

      // PutFullData (mask ignored) then Get on port 0
      txn(0, 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 5'd5);
      check("put_op", 64'(d_opcode[2:0]), 64'd0);
      check("put_src", 64'(d_source[4:0]), 64'd5);
      check("put_data", 64'(d_data[31:0]), 64'd0);
      txn(0, 3'd4, 32'h0000_0010, 32'h0, 4'h0, 5'd9);
      exp_q.push_back(32'hDEAD_BEEF);
      check("get_op", 64'(d_opcode[2:0]), 64'd1);
      check("get_src", 64'(d_source[4:0]), 64'd9);
      check("get_data", 64'(d_data[31:0]), 64'(exp_q.pop_front()));

      // PutPartialData over the same word; low address bits ignored on Get
      txn(0, 3'd1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 5'd3);
      txn(0, 3'd4, 32'h0000_0012, 32'h0, 4'h0, 5'd4);
      exp_q.push_back(32'hDE22_BE44);
      check("partial_data", 64'(d_data[31:0]), 64'(exp_q.pop_front()));

      // Write on port 1, Get from port 0 in the very next cycle
      txn(1, 3'd0, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 5'd1);
      txn(0, 3'd4, 32'h0000_0020, 32'h0, 4'h0, 5'd2);
      exp_q.push_back(32'hA5A5_5A5A);
      check("xport_data", 64'(d_data[31:0]), 64'(exp_q.pop_front()));

      // Address beyond DEPTH: denied with the range check, wraps without it
      txn(0, 3'd0, 32'h0000_0000, 32'h1234_5678, 4'hF, 5'd2);
      txn(0, 3'd0, 32'h0000_4000, 32'hCAFE_F00D, 4'hF, 5'd2);
`ifdef TL_SRAM_RANGE_CHECK_EN
      check("range_denied", 64'(d_denied[0]), 64'd1);
      exp_q.push_back(32'h1234_5678);
`else
      check("range_denied", 64'(d_denied[0]), 64'd0);
      exp_q.push_back(32'hCAFE_F00D);
`endif
      txn(0, 3'd4, 32'h0000_0000, 32'h0, 4'h0, 5'd2);
      check("range_word0", 64'(d_data[31:0]), 64'(exp_q.pop_front()));

      // Unknown opcode
      txn(1, 3'd7, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 5'd7);
      check("unk_denied", 64'(d_denied[1]), 64'd1);
      check("unk_op", 64'(d_opcode[5:3]), 64'd0);
      check("unk_data", 64'(d_data[63:32]), 64'd0);

      // Both ports streaming with d_ready high: grants alternate
      a_opcode  = {3'd4, 3'd4};
      a_address = {32'h0000_0020, 32'h0000_0010};
      a_size    = {4'd2, 4'd2};
      a_valid   = 2'b11;
      d_ready   = 2'b11;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 6; k++) begin
         cycle_step();
         if (seen_ready == 2'b01) c0++;
         if (seen_ready == 2'b10) c1++;
      end
      check("alt_port0", 64'(c0), 64'd3);
      check("alt_port1", 64'(c1), 64'd3);

      // Port 1 stalls its D channel: one grant for port 1, port 0 streams
      a_valid = 2'b01;
      cycle_step();
      a_valid = 2'b11;
      d_ready = 2'b01;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 6; k++) begin
         cycle_step();
         if (seen_ready == 2'b01) c0++;
         if (seen_ready == 2'b10) c1++;
      end
      check("stall_port0", 64'(c0), 64'd5);
      check("stall_port1", 64'(c1), 64'd1);
      a_valid = '0;
      d_ready = 2'b11;
      repeat (2) cycle_step();

      // Known contents for the random window
      for (int w = 0; w < 16; w++)
         txn(0, 3'd0, 32'h100 + 32'(w * 4), $urandom, 4'hF, 5'(w));
      a_valid = '0;

      // Randomized traffic on both ports
      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < NP; p++) begin
            int r;
            if (!a_valid[p] || last_grant == p) begin
               a_valid[p] = ($urandom_range(0, 3) != 0);
               r = $urandom_range(0, 4);
               a_opcode[p*3 +: 3] = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 :
                                    (r == 4) ? 3'd7 : 3'd4;
               a_address[p*AW +: AW] = 32'h100 + 32'($urandom_range(0, 15)) * 4 +
                                       32'($urandom_range(0, 3));
               a_data[p*DW +: DW]   = $urandom;
               a_mask[p*MW +: MW]   = 4'($urandom_range(0, 15));
               a_source[p*SW +: SW] = 5'($urandom_range(0, 31));
               a_size[p*4 +: 4]     = 4'($urandom_range(0, 2));
            end
            d_ready[p] = ($urandom_range(0, 3) != 0);
         end
         cycle_step();
      end
      a_valid = '0;
      d_ready = 2'b11;
      repeat (2) cycle_step();

      // Asynchronous reset with a response pending
      d_ready = 2'b00;
      txn(0, 3'd4, 32'h0000_0010, 32'h0, 4'h0, 5'd6);
      check("pre_rst_d_valid", 64'(d_valid[0]), 64'd1);
      a_valid = 2'b11;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_d_valid", 64'(d_valid), 64'd0);
      check("async_rst_a_ready", 64'(a_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      a_valid = '0;
      rst     = 1'b0;
      #1;
      check("post_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      check("post_rst_d_valid", 64'(d_valid), 64'd0);
      for (int p = 0; p < NP; p++) m_full[p] = 1'b0;
      m_rr = 0;
      @(negedge clk);
      d_ready = 2'b11;

      // Memory contents survive reset
      txn(1, 3'd4, 32'h0000_0010, 32'h0, 4'h0, 5'd8);
      exp_q.push_back(32'hDE22_BE44);
      check("post_rst_data", 64'(d_data[63:32]), 64'(exp_q.pop_front()));
      repeat (2) cycle_step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tl_sram_mp.md
# tl_sram_mp

Parametrised multi-port TileLink-UL SRAM slave: NUM_PORTS independent A/D channel pairs (e.g. Icache, Dcache, DMA) share one single-ported synchronous memory through a round-robin arbiter. Supports Get, PutFullData and PutPartialData with byte masks, one outstanding request per port, and a per-port D-channel response register. It replaces the fixed two-port Icache/Dcache SRAM top as the on-chip memory behind the cache buses.

## Interface
- NUM_PORTS, 2: number of TileLink ports; 1..8.
- DATA_W, 32: data width; multiple of 8.
- ADDR_W, 32: byte address width.
- DEPTH, 4096: memory words; power of two.
- SRC_W, 5: source ID width.
- BASE_ADDR, 32'h0: byte address of word 0.

Ports, vectors flattened with port p at slice [p*W +: W]:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- a_valid  in  NUM_PORTS  A request valid.
- a_ready  out  NUM_PORTS  A accepted this cycle.
- a_opcode  in  3*NUM_PORTS  0 PutFullData, 1 PutPartialData, 4 Get.
- a_size  in  4*NUM_PORTS  log2 bytes; echoed.
- a_mask  in  (DATA_W/8)*NUM_PORTS  byte enables.
- a_address  in  ADDR_W*NUM_PORTS  byte address.
- a_data  in  DATA_W*NUM_PORTS  write data.
- a_source  in  SRC_W*NUM_PORTS  request ID.
- d_valid  out  NUM_PORTS  response valid.
- d_ready  in  NUM_PORTS  response consumed.
- d_opcode  out  3*NUM_PORTS  0 AccessAck, 1 AccessAckData.
- d_size  out  4*NUM_PORTS  echo of a_size.
- d_source  out  SRC_W*NUM_PORTS  echo of a_source.
- d_data  out  DATA_W*NUM_PORTS  read data; 0 for AccessAck.
- d_denied  out  NUM_PORTS  request rejected.
- d_param, d_sink, d_corrupt: outputs, constant 0.

## Operation
- Per-port response slot: EMPTY / FULL. Port p is eligible when a_valid[p] and slot EMPTY, or slot FULL with d_ready[p] this cycle (pass-through refill).
- Arbiter: round-robin among eligible ports, search starting at rr_ptr; at most one a_ready bit high per cycle; rr_ptr <= winner+1 mod NUM_PORTS after each grant, unchanged when no grant.
- a_ready is combinational from a_valid, slot state and d_ready; a_ready[p] never high with a_valid[p] low.
- Word index = (a_address - BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH) bits; low address bits ignored.
- PutFullData: all bytes written regardless of mask. PutPartialData: only bytes with mask bit 1 written. Get: mask ignored.
- Unknown opcode: no memory access, response AccessAck, d_denied=1.
- Memory contents are not reset.

## Timing
- Cycle N: A handshake on winner; write committed at edge ending N; read issued at same edge.
- Cycle N+1: d_valid[winner]=1 with registered fields; Get data reflects all writes committed through cycle N-1.
- Response held stable until d_valid&d_ready; slot returns EMPTY at that edge unless refilled same cycle.
- Back-to-back single port: one transaction per cycle when d_ready held high.
- NUM_PORTS contenders all valid, d_ready high: each port granted once every NUM_PORTS cycles.
- Write then Get same word from another port in following cycle: Get returns new data.
- Reset values: d_valid=0, a_ready=0, d_opcode/d_size/d_source/d_data/d_denied=0, rr_ptr=0, all slots EMPTY. Reset mid-transaction discards pending responses; an A beat accepted in the reset cycle is lost and a write in that cycle is not guaranteed.

## Configuration
- TL_SRAM_RANGE_CHECK_EN defined: address below BASE_ADDR or word index >= DEPTH -> no memory access, d_denied=1, d_data=0, opcode per request type; also a_size > log2(DATA_W/8) denied.
- Undefined: no check; index wraps modulo DEPTH, d_denied always 0 except unknown opcode.

## Test plan
- Reset: assert rst mid-stream with d_valid high -> all d_valid and a_ready 0 asynchronously, rr_ptr 0 after release.
- Port 0 PutFullData 0x0000_0010 data 0xDEADBEEF, then Get same address -> AccessAck, then AccessAckData 0xDEADBEEF one cycle after each handshake, source echoed.
- PutPartialData mask 4'b0101 data 0x11223344 over 0xDEADBEEF -> subsequent Get returns 0xDE22BE44.
- Ports 0 and 1 valid continuously, d_ready high -> grants alternate 0,1,0,1; with d_ready[1] low port 1 gets one grant then a_ready[1] stays 0 while port 0 streams every cycle.
- Write from port 1 cycle N, Get same word from port 0 cycle N+1 -> new data returned.
- With TL_SRAM_RANGE_CHECK_EN, DEPTH=4096: Put at byte 0x4000 -> d_denied=1, memory word 0 unchanged; without macro -> word 0 written.
